// File: rtl/line_buffer_pkg.sv
// Shared ASCII codes, printable range and FSM state encodings for the
// keyboard line-editing stage.
package line_buffer_pkg;

  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  localparam logic [1:0] ST_EDIT = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_TERM = 2'd2;

  // True for codes that are stored in the line (space through tilde).
  function automatic logic is_printable(input logic [7:0] code);
    return (code >= ASCII_PRINT_LO) && (code <= ASCII_PRINT_HI);
  endfunction

endpackage

// File: rtl/line_buffer_if.sv
// Edit-strobe input, valid/ready output stream and status flags of the
// line buffer. The slave modport is the line buffer itself, the master
// modport is the surrounding keyboard/consumer logic.
interface line_buffer_if #(
  parameter int ADDR_W = 4
);
  logic              i_en;
  logic [7:0]        i_ascii;
  logic [7:0]        o_dat;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W:0]   o_len;
  logic              o_full;
  logic              o_busy;
  logic              o_drop;

  modport master (
    output i_en, i_ascii, i_ready,
    input  o_dat, o_valid, o_len, o_full, o_busy, o_drop
  );

  modport slave (
    input  i_en, i_ascii, i_ready,
    output o_dat, o_valid, o_len, o_full, o_busy, o_drop
  );
endinterface

// File: rtl/line_buffer_ram.sv
// Character storage for one line: synchronous write, asynchronous read.
module line_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdat,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdat
);

  logic [7:0] mem [DEPTH];

  // Store a character at the write address when enabled.
  // NOTE: contents carry no reset; len gates which entries are meaningful,
  // so clearing them would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/line_buffer.sv
// Line editor: collects printable characters, applies backspace, and on
// Enter streams the line followed by a carriage return over valid/ready.
module line_buffer
  import line_buffer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        i_sclr,
  line_buffer_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              drop_q, drop_d;
  logic              we;
  logic [7:0]        rdat;

  line_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (len_q[ADDR_W-1:0]),
    .wdat  (bus.i_ascii),
    .raddr (rd_ptr_q),
    .rdat  (rdat)
  );

  // Next-state logic for the edit/send/terminate sequence.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = 1'b0;
    we       = 1'b0;
    case (state_q)
      ST_EDIT: begin
        if (bus.i_en) begin
          if (is_printable(bus.i_ascii)) begin
            if (len_q < DEPTH_L) begin
              we    = 1'b1;
              len_d = len_q + 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end else if (bus.i_ascii == ASCII_BS) begin
            if (len_q != '0) len_d = len_q - 1'b1;
          end else if (bus.i_ascii == ASCII_CR) begin
            rd_ptr_d = '0;
            state_d  = (len_q != '0) ? ST_SEND : ST_TERM;
          end
        end
      end
      ST_SEND: begin
        drop_d = bus.i_en;
        if (bus.i_ready) begin
          if ({1'b0, rd_ptr_q} == len_q - 1'b1) state_d = ST_TERM;
          else rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      ST_TERM: begin
        drop_d = bus.i_en;
        if (bus.i_ready) begin
          len_d    = '0;
          rd_ptr_d = '0;
          state_d  = ST_EDIT;
        end
      end
      default: state_d = ST_EDIT;
    endcase
  end

  // State registers; reset abandons any line in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge.
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      state_q  <= ST_EDIT;
      len_q    <= '0;
      rd_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
    end
  end

  // Outputs depend on registered state only, never on i_ready.
  always_comb begin
    case (state_q)
      ST_SEND: bus.o_dat = rdat;
      ST_TERM: bus.o_dat = ASCII_CR;
      default: bus.o_dat = 8'h00;
    endcase
  end

  assign bus.o_valid = (state_q == ST_SEND) || (state_q == ST_TERM);
  assign bus.o_busy  = bus.o_valid;
  assign bus.o_len   = len_q;
  assign bus.o_full  = (len_q == DEPTH_L);
  assign bus.o_drop  = drop_q;

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_line_buffer;
  import line_buffer_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic i_sclr;
  always #5 clk = ~clk;

  line_buffer_if #(.ADDR_W(ADDR_W)) bus ();

  line_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .i_sclr (i_sclr),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the line being edited and the bytes still to be sent.
  logic [7:0] line_m[$];
  logic [7:0] stream_m[$];
  bit         drop_m;

  task automatic model_reset();
    line_m.delete();
    stream_m.delete();
    drop_m = 0;
  endtask

  task automatic model_edge(input logic en, input logic [7:0] a, input logic rdy);
    logic [7:0] tmp;
    drop_m = 0;
    if (stream_m.size() != 0) begin
      if (en) drop_m = 1;
      if (rdy) begin
        tmp = stream_m.pop_front();
        if (stream_m.size() == 0) line_m.delete();
      end
    end else if (en) begin
      if (a >= 8'h20 && a <= 8'h7E) begin
        if (line_m.size() < DEPTH) line_m.push_back(a);
        else drop_m = 1;
      end else if (a == 8'h08) begin
        if (line_m.size() > 0) tmp = line_m.pop_back();
      end else if (a == 8'h0D) begin
        stream_m = line_m;
        stream_m.push_back(8'h0D);
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "/valid"}, bus.o_valid, stream_m.size() != 0);
    if (stream_m.size() != 0) check({tag, "/dat"}, bus.o_dat, stream_m[0]);
    check({tag, "/len"},  bus.o_len,  line_m.size());
    check({tag, "/full"}, bus.o_full, line_m.size() == DEPTH);
    check({tag, "/busy"}, bus.o_busy, stream_m.size() != 0);
    check({tag, "/drop"}, bus.o_drop, drop_m);
  endtask

  // Drive inputs for one cycle, clock, update the model, compare.
  task automatic step(input logic en, input logic [7:0] a, input logic rdy, input string tag);
    bus.i_en    = en;
    bus.i_ascii = a;
    bus.i_ready = rdy;
    @(posedge clk);
    model_edge(en, a, rdy);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    i_sclr      = 1'b1;
    bus.i_en    = 1'b0;
    bus.i_ascii = 8'h00;
    bus.i_ready = 1'b0;
    @(posedge clk);
    #1;
    i_sclr = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    logic [7:0] ascii;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_dat;
    logic [4:0] exp_len;
    logic       exp_drop;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(logic en, logic [7:0] a, logic rdy, logic v, logic [7:0] d,
                              logic [4:0] l, logic dr);
    vec_t r;
    r.en = en; r.ascii = a; r.rdy = rdy;
    r.exp_valid = v; r.exp_dat = d; r.exp_len = l; r.exp_drop = dr;
    return r;
  endfunction

  initial begin
    tv[0]  = mk(1, 8'h41, 1, 0, 8'h00, 1, 0);
    tv[1]  = mk(1, 8'h62, 1, 0, 8'h00, 2, 0);
    tv[2]  = mk(1, 8'h31, 1, 0, 8'h00, 3, 0);
    tv[3]  = mk(1, 8'h0D, 1, 1, 8'h41, 3, 0);
    tv[4]  = mk(0, 8'h00, 1, 1, 8'h62, 3, 0);
    tv[5]  = mk(0, 8'h00, 1, 1, 8'h31, 3, 0);
    tv[6]  = mk(0, 8'h00, 1, 1, 8'h0D, 3, 0);
    tv[7]  = mk(0, 8'h00, 1, 0, 8'h00, 0, 0);
    tv[8]  = mk(1, 8'h78, 1, 0, 8'h00, 1, 0);
    tv[9]  = mk(1, 8'h79, 1, 0, 8'h00, 2, 0);
    tv[10] = mk(1, 8'h08, 1, 0, 8'h00, 1, 0);
    tv[11] = mk(1, 8'h7A, 1, 0, 8'h00, 2, 0);
    tv[12] = mk(1, 8'h0D, 1, 1, 8'h78, 2, 0);
    tv[13] = mk(0, 8'h00, 1, 1, 8'h7A, 2, 0);
    tv[14] = mk(0, 8'h00, 1, 1, 8'h0D, 2, 0);
    tv[15] = mk(0, 8'h00, 1, 0, 8'h00, 0, 0);
    tv[16] = mk(1, 8'h08, 1, 0, 8'h00, 0, 0);
    tv[17] = mk(1, 8'h00, 1, 0, 8'h00, 0, 0);

    // Reset values.
    do_reset();
    check("rst/valid", bus.o_valid, 1'b0);
    check("rst/dat",   bus.o_dat,   8'h00);
    check("rst/len",   bus.o_len,   5'd0);
    check("rst/full",  bus.o_full,  1'b0);
    check("rst/busy",  bus.o_busy,  1'b0);
    check("rst/drop",  bus.o_drop,  1'b0);

    // Directed vector table.
    for (int i = 0; i < 18; i++) begin
      bus.i_en    = tv[i].en;
      bus.i_ascii = tv[i].ascii;
      bus.i_ready = tv[i].rdy;
      @(posedge clk);
      model_edge(tv[i].en, tv[i].ascii, tv[i].rdy);
      #1;
      check($sformatf("vec%0d/valid", i), bus.o_valid, tv[i].exp_valid);
      if (tv[i].exp_valid) check($sformatf("vec%0d/dat", i), bus.o_dat, tv[i].exp_dat);
      check($sformatf("vec%0d/len", i),  bus.o_len,  tv[i].exp_len);
      check($sformatf("vec%0d/drop", i), bus.o_drop, tv[i].exp_drop);
    end

    // Fill to DEPTH, one extra strobe is dropped, then stream all.
    for (int i = 0; i < DEPTH; i++) step(1, 8'h61 + 8'(i), 1, "fill");
    check("fill/full_at_depth", bus.o_full, 1'b1);
    step(1, 8'h5A, 1, "over");
    check("over/drop_pulse", bus.o_drop, 1'b1);
    step(0, 8'h00, 1, "over_idle");
    check("over/drop_once", bus.o_drop, 1'b0);
    step(1, 8'h0D, 1, "full_enter");
    for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 1, "full_send");
    check("full/len_after", bus.o_len, 5'd0);

    // Stalled stream with strobes arriving during SEND.
    for (int i = 0; i < 5; i++) step(1, 8'h30 + 8'(i), 1, "stall_type");
    step(1, 8'h0D, 1, "stall_enter");
    begin
      logic [7:0] pat;
      pat = 8'b1001_1001;
      for (int i = 0; i < 40 && stream_m.size() != 0; i++)
        step(i[0], 8'h4B, pat[i % 8], "stall");
      check("stall/drained", stream_m.size(), 0);
    end

    // Enter on an empty line: one terminator beat.
    step(1, 8'h0D, 1, "empty_enter");
    check("empty/busy", bus.o_busy, 1'b1);
    check("empty/dat",  bus.o_dat,  8'h0D);
    step(0, 8'h00, 1, "empty_done");
    check("empty/busy_after", bus.o_busy, 1'b0);

    // Strobe in the same cycle the terminator is accepted is dropped.
    step(1, 8'h71, 1, "term_type");
    step(1, 8'h0D, 1, "term_enter");
    step(0, 8'h00, 1, "term_data");
    step(1, 8'h72, 1, "term_accept");
    check("term/drop", bus.o_drop, 1'b1);
    check("term/len",  bus.o_len,  5'd0);

    // Asynchronous reset in the middle of SEND.
    for (int i = 0; i < 4; i++) step(1, 8'h50 + 8'(i), 1, "mid_type");
    step(1, 8'h0D, 1, "mid_enter");
    step(0, 8'h00, 1, "mid_send");
    #2;
    i_sclr = 1'b1;
    #1;
    check("mid/valid_async", bus.o_valid, 1'b0);
    check("mid/busy_async",  bus.o_busy,  1'b0);
    @(posedge clk);
    #1;
    i_sclr = 1'b0;
    model_reset();
    compare_model("mid_released");
    step(1, 8'h68, 1, "post_type");
    step(1, 8'h69, 1, "post_type");
    step(1, 8'h0D, 1, "post_enter");
    check("post/dat0", bus.o_dat, 8'h68);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, "post_send");
    check("post/len", bus.o_len, 5'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a;
      int r;
      r = $urandom_range(0, 15);
      if (r < 2)       a = 8'h0D;
      else if (r == 2) a = 8'h08;
      else if (r == 3) a = 8'h00;
      else if (r == 4) a = 8'($urandom_range(0, 255));
      else             a = 8'($urandom_range(32, 126));
      step($urandom_range(0, 2) != 0, a, $urandom_range(0, 3) != 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
